// File: rtl/bp_cce_pkg.sv
// Shared types and helpers for the CCE pending-bit write arbiter.
package bp_cce_pkg;

    typedef enum logic {
        e_pa_sweep = 1'b0,
        e_pa_ready = 1'b1
    } bp_cce_pending_arb_state_e;

    // Width of an index into x items; a single item still needs one bit.
    function automatic int bp_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_cce_rr_arb.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr_i (wrapping) wins. The pointer register lives in the parent.
module bp_cce_rr_arb
    import bp_cce_pkg::*;
#(
    parameter int num_req_p = 3,
    localparam int lg_num_req_lp = bp_safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]     req_i,
    input  logic [lg_num_req_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]     grant_o,
    output logic [lg_num_req_lp-1:0] grant_idx_o
);

    logic [lg_num_req_lp-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        idx         = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = lg_num_req_lp'((int'(ptr_i) + k) % num_req_p);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/bp_cce_pending_arbiter.sv
// Arbiter and sequencer for the single write port of the CCE pending-bit
// counter array. Clears every way group after reset or on init_i, then
// round-robins agent writes through a registered output stage.
//
// state      | meaning
// -----------+----------------------------------------------------------
// e_pa_sweep | issuing one clear per cycle to way groups 0..N-1, no grants
// e_pa_ready | arbitrating agent requests, init_done_o high
module bp_cce_pending_arbiter
    import bp_cce_pkg::*;
#(
    parameter int num_req_p        = 3,
    parameter int num_way_groups_p = 8,
    parameter int addr_width_p     = 8,
    localparam int lg_num_req_lp        = bp_safe_clog2(num_req_p),
    localparam int lg_num_way_groups_lp = bp_safe_clog2(num_way_groups_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              init_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p-1:0]              req_bypass_hash_i,
    input  logic [num_req_p-1:0]              req_pending_i,
    input  logic [num_req_p-1:0]              req_clear_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              w_v_o,
    output logic [addr_width_p-1:0]           w_addr_o,
    output logic                              w_addr_bypass_hash_o,
    output logic                              w_pending_o,
    output logic                              w_clear_o,
    output logic [lg_num_req_lp-1:0]          w_src_o,
    output logic                              init_done_o
);

    // Write-port register; widths follow the instance parameters.
    typedef struct packed {
        logic                     v;
        logic [addr_width_p-1:0]  addr;
        logic                     bypass_hash;
        logic                     pending;
        logic                     clear;
        logic [lg_num_req_lp-1:0] src;
    } bp_cce_pending_wr_s;

    localparam logic [lg_num_way_groups_lp-1:0] last_wg_lp =
        lg_num_way_groups_lp'(num_way_groups_p - 1);
    localparam logic [lg_num_req_lp-1:0] last_req_lp =
        lg_num_req_lp'(num_req_p - 1);

    bp_cce_pending_arb_state_e       state_q, state_d;
    logic [lg_num_way_groups_lp-1:0] cnt_q, cnt_d;
    logic [lg_num_req_lp-1:0]        ptr_q, ptr_d;
    bp_cce_pending_wr_s              wr_q, wr_d;

    logic [num_req_p-1:0]     grant;
    logic [lg_num_req_lp-1:0] grant_idx;
    logic [addr_width_p-1:0]  sel_addr;
    logic                     sel_bypass_hash;
    logic                     sel_pending;
    logic                     sel_clear;

    bp_cce_rr_arb #(
        .num_req_p (num_req_p)
    ) rr_arb (
        .req_i       (req_v_i),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Pick the winning agent's fields with the one-hot grant.
    always_comb begin
        sel_addr        = '0;
        sel_bypass_hash = 1'b0;
        sel_pending     = 1'b0;
        sel_clear       = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                sel_addr        = req_addr_i[i*addr_width_p +: addr_width_p];
                sel_bypass_hash = req_bypass_hash_i[i];
                sel_pending     = req_pending_i[i];
                sel_clear       = req_clear_i[i];
            end
        end
    end

    // Next-state, sweep counter, pointer, grant and output-register load.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_d        = '0;
        req_ready_o = '0;
        case (state_q)
            e_pa_sweep: begin
                wr_d.v           = 1'b1;
                wr_d.addr        = addr_width_p'(cnt_q);
                wr_d.bypass_hash = 1'b1;
                wr_d.clear       = 1'b1;
                if (cnt_q == last_wg_lp) begin
                    cnt_d   = '0;
                    state_d = e_pa_ready;
                end else begin
                    cnt_d = cnt_q + lg_num_way_groups_lp'(1);
                end
            end
            e_pa_ready: begin
                // A sweep request wins over any pending grant this cycle.
                if (init_i) begin
                    state_d = e_pa_sweep;
                    cnt_d   = '0;
                end else if (|grant) begin
                    req_ready_o      = grant;
                    wr_d.v           = 1'b1;
                    wr_d.addr        = sel_addr;
                    wr_d.bypass_hash = sel_bypass_hash;
                    wr_d.pending     = sel_pending;
                    wr_d.clear       = sel_clear;
                    wr_d.src         = grant_idx;
                    ptr_d = (grant_idx == last_req_lp) ? '0
                          : grant_idx + lg_num_req_lp'(1);
                end
            end
            default: state_d = e_pa_sweep;
        endcase
    end

    // State, counter, pointer and output register; reset drops any write.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_pa_sweep;
            cnt_q   <= '0;
            ptr_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
        end
    end

    assign w_v_o                = wr_q.v;
    assign w_addr_o             = wr_q.addr;
    assign w_addr_bypass_hash_o = wr_q.bypass_hash;
    assign w_pending_o          = wr_q.pending;
    assign w_clear_o            = wr_q.clear;
    assign w_src_o              = wr_q.src;
    assign init_done_o          = (state_q == e_pa_ready);

endmodule

// File: tb/tb_bp_cce_pending_arbiter.sv
// Directed bench for bp_cce_pending_arbiter: 3 agents, 8 way groups, 8-bit addresses.
module tb_bp_cce_pending_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        init_i;
    logic [2:0]  req_v_i;
    logic [23:0] req_addr_i;
    logic [2:0]  req_bypass_hash_i;
    logic [2:0]  req_pending_i;
    logic [2:0]  req_clear_i;
    logic [2:0]  req_ready_o;
    logic        w_v_o;
    logic [7:0]  w_addr_o;
    logic        w_addr_bypass_hash_o;
    logic        w_pending_o;
    logic        w_clear_o;
    logic [1:0]  w_src_o;
    logic        init_done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_cce_pending_arbiter #(
        .num_req_p        (3),
        .num_way_groups_p (8),
        .addr_width_p     (8)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .init_i               (init_i),
        .req_v_i              (req_v_i),
        .req_addr_i           (req_addr_i),
        .req_bypass_hash_i    (req_bypass_hash_i),
        .req_pending_i        (req_pending_i),
        .req_clear_i          (req_clear_i),
        .req_ready_o          (req_ready_o),
        .w_v_o                (w_v_o),
        .w_addr_o             (w_addr_o),
        .w_addr_bypass_hash_o (w_addr_bypass_hash_o),
        .w_pending_o          (w_pending_o),
        .w_clear_o            (w_clear_o),
        .w_src_o              (w_src_o),
        .init_done_o          (init_done_o)
    );

    // Inputs of a row, the combinational grant expected for them, and the
    // registered write expected from the previous row's transfer.
    typedef struct {
        logic [2:0]  req_v;
        logic [23:0] addr;
        logic [2:0]  byp;
        logic [2:0]  pend;
        logic [2:0]  clr;
        logic [2:0]  exp_ready;
        logic        exp_v;
        logic [7:0]  exp_addr;
        logic        exp_byp;
        logic        exp_pend;
        logic        exp_clr;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Eight clear writes to way groups 0..7; optionally pulse init_i mid-sweep.
    task automatic check_sweep(input string tag, input bit init_mid, input logic [2:0] last_ready);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("%s k%0d w_v", tag, k), 32'(w_v_o), 32'd1);
            chk($sformatf("%s k%0d w_addr", tag, k), 32'(w_addr_o), 32'(k));
            chk($sformatf("%s k%0d bypass", tag, k), 32'(w_addr_bypass_hash_o), 32'd1);
            chk($sformatf("%s k%0d clear", tag, k), 32'(w_clear_o), 32'd1);
            chk($sformatf("%s k%0d pending", tag, k), 32'(w_pending_o), 32'd0);
            chk($sformatf("%s k%0d src", tag, k), 32'(w_src_o), 32'd0);
            chk($sformatf("%s k%0d ready", tag, k), 32'(req_ready_o),
                (k == 7) ? 32'(last_ready) : 32'd0);
            chk($sformatf("%s k%0d done", tag, k), 32'(init_done_o), (k == 7) ? 32'd1 : 32'd0);
            init_i = init_mid && (k == 3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // agent fields for the multi-agent rows: a0=10, a1=11, a2=12
        vt[0]  = '{3'b000, 24'h0,      3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 2'd0};
        vt[1]  = '{3'b010, 24'h004000, 3'b000, 3'b010, 3'b000, 3'b010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[2]  = '{3'b100, 24'h224000, 3'b100, 3'b000, 3'b000, 3'b100, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 2'd1};
        vt[3]  = '{3'b111, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b001, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 2'd2};
        vt[4]  = '{3'b111, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b010, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[5]  = '{3'b111, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b100, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 2'd1};
        vt[6]  = '{3'b111, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b001, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 2'd2};
        vt[7]  = '{3'b111, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b010, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[8]  = '{3'b111, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b100, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 2'd1};
        vt[9]  = '{3'b100, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b100, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 2'd2};
        vt[10] = '{3'b000, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b000, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 2'd2};
        vt[11] = '{3'b101, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[12] = '{3'b101, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b100, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[13] = '{3'b001, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b001, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 2'd2};
        vt[14] = '{3'b000, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b000, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[15] = '{3'b000, 24'h121110, 3'b010, 3'b101, 3'b100, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};

        reset_n_i         = 1'b0;
        init_i            = 1'b0;
        req_v_i           = '0;
        req_addr_i        = '0;
        req_bypass_hash_i = '0;
        req_pending_i     = '0;
        req_clear_i       = '0;

        #2;
        chk("reset w_v", 32'(w_v_o), 32'd0);
        chk("reset w_addr", 32'(w_addr_o), 32'd0);
        chk("reset w_clear", 32'(w_clear_o), 32'd0);
        chk("reset w_src", 32'(w_src_o), 32'd0);
        chk("reset ready", 32'(req_ready_o), 32'd0);
        chk("reset done", 32'(init_done_o), 32'd0);
        #21;
        reset_n_i = 1'b1;

        check_sweep("boot", 1'b0, 3'b000);

        // Table rows: each row's w_* reflect the previous row's transfer.
        for (int r = 0; r < 16; r++) begin
            req_v_i           = vt[r].req_v;
            req_addr_i        = vt[r].addr;
            req_bypass_hash_i = vt[r].byp;
            req_pending_i     = vt[r].pend;
            req_clear_i       = vt[r].clr;
            #1;
            chk($sformatf("row%0d ready", r), 32'(req_ready_o), 32'(vt[r].exp_ready));
            chk($sformatf("row%0d w_v", r), 32'(w_v_o), 32'(vt[r].exp_v));
            chk($sformatf("row%0d done", r), 32'(init_done_o), 32'd1);
            if (vt[r].exp_v) begin
                chk($sformatf("row%0d w_addr", r), 32'(w_addr_o), 32'(vt[r].exp_addr));
                chk($sformatf("row%0d bypass", r), 32'(w_addr_bypass_hash_o), 32'(vt[r].exp_byp));
                chk($sformatf("row%0d pending", r), 32'(w_pending_o), 32'(vt[r].exp_pend));
                chk($sformatf("row%0d clear", r), 32'(w_clear_o), 32'(vt[r].exp_clr));
                chk($sformatf("row%0d src", r), 32'(w_src_o), 32'(vt[r].exp_src));
            end
            @(posedge clk_i);
            #1;
        end

        // init_i beats arbitration; stalled agents 0 and 2 resume from pointer 1.
        init_i  = 1'b1;
        req_v_i = 3'b101;
        #1;
        chk("init ready", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        init_i = 1'b0;
        chk("init w_v", 32'(w_v_o), 32'd0);
        chk("init done", 32'(init_done_o), 32'd0);
        chk("init stall ready", 32'(req_ready_o), 32'd0);
        check_sweep("resweep", 1'b0, 3'b100);
        @(posedge clk_i);
        #1;
        req_v_i = 3'b001;
        #1;
        chk("resume w_src", 32'(w_src_o), 32'd2);
        chk("resume w_addr", 32'(w_addr_o), 32'h12);
        chk("resume ready", 32'(req_ready_o), 32'b001);
        @(posedge clk_i);
        #1;
        req_v_i = 3'b000;
        chk("resume2 w_v", 32'(w_v_o), 32'd1);
        chk("resume2 w_src", 32'(w_src_o), 32'd0);
        chk("resume2 w_addr", 32'(w_addr_o), 32'h10);

        // Reset during a sweep at counter 3, then a clean restart from addr 0.
        init_i = 1'b1;
        @(posedge clk_i);
        #1;
        init_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("midsweep w_v", 32'(w_v_o), 32'd1);
        chk("midsweep w_addr", 32'(w_addr_o), 32'd2);
        reset_n_i = 1'b0;
        #1;
        chk("async rst w_v", 32'(w_v_o), 32'd0);
        chk("async rst w_clear", 32'(w_clear_o), 32'd0);
        chk("async rst done", 32'(init_done_o), 32'd0);
        #2;
        reset_n_i = 1'b1;
        check_sweep("restart", 1'b1, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
